// File: rtl/nibble_serial_alu.sv
// -----------------------------------------------------------------------------
// nibble_serial_alu
//   Area-lean WIDTH-bit ALU (ADD/AND/OR/XOR). The operation is spread over
//   WIDTH/4 cycles, one 4-bit nibble per cycle, LSB nibble first, through a
//   single myALU slice. The carry between nibbles is kept in a register.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request valid
//   in_ready   out  request can be accepted (state IDLE)
//   a, b       in   WIDTH-bit operands, sampled only on the acceptance edge
//   fn         in   2'b00 ADD, 2'b01 AND, 2'b10 OR, 2'b11 XOR
//   cIn        in   carry-in, used for ADD only
//   out_valid  out  result valid (state DONE)
//   out_ready  in   consumer takes the result
//   result     out  registered WIDTH-bit result
//   cOut, N, Z, V   registered carry-out / negative / zero / overflow flags
//
// myALU
//   Combinational 4-bit slice shared by every nibble cycle.
// -----------------------------------------------------------------------------

module myALU (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] fn,
  input  logic       cIn,
  output logic [3:0] result,
  output logic       cOut,
  output logic       N,
  output logic       Z,
  output logic       V
);

  logic [4:0] sum_s;

  // 4-bit function select; logical ops never produce carry or overflow
  always_comb begin
    sum_s  = {1'b0, a} + {1'b0, b} + {4'b0000, cIn};
    result = 4'b0000;
    cOut   = 1'b0;
    V      = 1'b0;
    case (fn)
      2'b00: begin
        result = sum_s[3:0];
        cOut   = sum_s[4];
        V      = (~a[3] & ~b[3] & sum_s[3]) | (a[3] & b[3] & ~sum_s[3]);
      end
      2'b01:   result = a & b;
      2'b10:   result = a | b;
      2'b11:   result = a ^ b;
      default: result = 4'b0000;
    endcase
    N = result[3];
    Z = (result == 4'b0000);
  end

endmodule

module nibble_serial_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       fn,
  input  logic             cIn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cOut,
  output logic             N,
  output logic             Z,
  output logic             V
);

  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [1:0]    FN_ADD = 2'b00;
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("nibble_serial_alu: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;     // operands shift right one nibble per RUN cycle,
  logic [WIDTH-1:0] opb_q, opb_d;     // so the current nibble is always bits [3:0]
  logic [1:0]       fn_q, fn_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic             zacc_q, zacc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             n_q, n_d;
  logic             z_q, z_d;
  logic             v_q, v_d;

  logic [3:0]       slice_res_s;
  logic             slice_cout_s;
  logic             slice_n_s;
  logic             slice_z_s;
  logic             slice_v_s;

  myALU u_slice (
    .a      (opa_q[3:0]),
    .b      (opb_q[3:0]),
    .fn     (fn_q),
    .cIn    (carry_q),
    .result (slice_res_s),
    .cOut   (slice_cout_s),
    .N      (slice_n_s),
    .Z      (slice_z_s),
    .V      (slice_v_s)
  );

  // Handshake outputs come straight from the state register
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign cOut      = cout_q;
  assign N         = n_q;
  assign Z         = z_q;
  assign V         = v_q;

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    fn_d     = fn_q;
    k_d      = k_q;
    carry_d  = carry_q;
    zacc_d   = zacc_q;
    result_d = result_q;
    cout_d   = cout_q;
    n_d      = n_q;
    z_d      = z_q;
    v_d      = v_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d    = a;
          opb_d    = b;
          fn_d     = fn;
          // carry register doubles as the nibble-0 carry-in; logical ops get 0
          carry_d  = (fn == FN_ADD) ? cIn : 1'b0;
          k_d      = '0;
          zacc_d   = 1'b1;
          result_d = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        opa_d    = opa_q >> 3'd4;
        opb_d    = opb_q >> 3'd4;
        carry_d  = slice_cout_s;
        zacc_d   = zacc_q & slice_z_s;
        // result fills from the top: after NIB shifts nibble k sits at [4k+3:4k]
        result_d = (result_q >> 3'd4) | (WIDTH'(slice_res_s) << (WIDTH - 4));
        if (k_q == K_LAST) begin
          k_d     = '0;
          cout_d  = slice_cout_s;
          n_d     = slice_n_s;
          v_d     = slice_v_s;
          z_d     = zacc_q & slice_z_s;
          state_d = DONE;
        end else begin
          k_d     = k_q + KW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, fully cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      fn_q     <= 2'b00;
      k_q      <= '0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      fn_q     <= fn_d;
      k_q      <= k_d;
      carry_q  <= carry_d;
      zacc_q   <= zacc_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      n_q      <= n_d;
      z_q      <= z_d;
      v_q      <= v_d;
    end
  end

endmodule

// File: doc/nibble_serial_alu.md
# nibble_serial_alu

Multi-cycle, WIDTH-bit ALU that computes ADD/AND/OR/XOR one 4-bit nibble per cycle by driving a single instance of the team's 4-bit `myALU` slice.

- Operands are latched on a valid/ready handshake and processed LSB nibble first.
- The carry is chained between nibbles through a register.
- The final result, carry-out and N/Z/V flags are returned on a second valid/ready handshake.
- It sits between a wide-datapath producer and consumer wherever area matters more than latency.

## Interface

**Parameters**
- `WIDTH`, default 16: operand and result width. Must be a multiple of 4 and ≥4; any other value is an elaboration error.
- `NIB`, derived as WIDTH/4: number of nibble cycles per operation.

**Ports**
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `fn`  in  2  operation, type `mode`: 00 ADD, 01 AND, 10 OR, 11 XOR.
- `cIn`  in  1  carry-in; used for ADD only.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  WIDTH  registered result.
- `cOut`  out  1  carry out of bit WIDTH-1 (ADD); 0 otherwise.
- `N`  out  1  `result[WIDTH-1]`.
- `Z`  out  1  1 iff `result` == 0.
- `V`  out  1  two's-complement overflow (ADD); 0 otherwise.

## Operation

- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - `in_ready`=1.
  - When `in_valid`&&`in_ready` at a clock edge: latch `a`, `b`, `fn`, `cIn`; clear the nibble counter, the zero accumulator and the result register; go to RUN.
- **RUN:**
  - Nibble counter k counts 0..NIB-1.
  - The slice receives `a[4k+3:4k]`, `b[4k+3:4k]` and the latched `fn`.
  - Slice carry-in: for k=0, the latched `cIn` if `fn`==ADD, else 0. For k>0, the registered slice `cOut` from nibble k-1.
  - At each edge: write the slice result into `result[4k+3:4k]`, register the slice `cOut`, AND the slice Z into the zero accumulator.
  - At k=NIB-1: capture the final `cOut`, `N`=slice N, `V`=slice V, `Z`=accumulated zero; go to DONE.
- **DONE:**
  - `out_valid`=1; all outputs held stable.
  - On `out_valid`&&`out_ready`: go to IDLE.
- **Logical ops (AND/OR/XOR):** `cOut`=0 and `V`=0 regardless of `cIn`.
- **Arithmetic:** `{cOut, result}` = `a` + `b` + `cIn`, computed modulo 2^(WIDTH+1). `V`=(~a[MSB]&~b[MSB]&r[MSB]) | (a[MSB]&b[MSB]&~r[MSB]).
- **Operand stability:** `a`, `b`, `fn`, `cIn` are ignored outside the acceptance edge. Changing them during RUN or DONE has no effect.
- **Single outstanding operation:** `in_ready`=0 in RUN and DONE, so `in_valid` pulses there are ignored. No acceptance happens in the same cycle as result release.
- **Outputs during RUN:** `result`, `cOut`, `N`, `Z`, `V` are don't-care while `out_valid`=0, but must not glitch while `out_valid`=1.

## Timing

- `in_ready` and `out_valid` are decoded directly from the state register; no combinational path from inputs.
- **Reset** (async assert, sync deassert by the system):
  - State goes to IDLE.
  - `in_ready`=1, `out_valid`=0.
  - `result`=0, `cOut`=0, `N`=0, `Z`=0, `V`=0.
  - Carry and nibble counter cleared.
- **Latency:** acceptance edge ends cycle c0; nibble k is computed in cycle c0+1+k; `out_valid`=1 from cycle c0+1+NIB. For WIDTH=16 that is 4 RUN cycles, with `out_valid` in cycle c0+5.
- **Release:** the edge with `out_valid`&&`out_ready` returns the block to IDLE; `in_ready`=1 the next cycle.
- **Throughput:** best case one operation per NIB+2 cycles.
- **Backpressure:** DONE is held indefinitely while `out_ready`=0.
- **Reset mid-operation (RUN or DONE):** the operation is aborted and discarded; no `out_valid` pulse. No carry or zero state survives into the next operation.
- **WIDTH=4:** one RUN cycle; behaviour is identical to a registered `myALU`.

## Test plan

All scenarios use WIDTH=16.

1. **ADD, signed overflow:** `a`=0x7FFF, `b`=0x0001, `cIn`=0 -> `result`=0x8000, `cOut`=0, `N`=1, `Z`=0, `V`=1, with `out_valid` first high exactly 5 cycles after acceptance.
2. **ADD, carry ripple:** `a`=0xFFFF, `b`=0x0000, `cIn`=1 -> `result`=0x0000, `cOut`=1, `Z`=1, `N`=0, `V`=0. This proves the carry ripples across all 4 nibbles.
3. **Logical ops:** `a`=0xF0F0, `b`=0xFF00, `cIn`=1 ->
   - AND gives 0xF000 with `N`=1.
   - OR gives 0xFFF0.
   - XOR gives 0x0FF0 with `N`=0.
   - All three have `cOut`=0 and `V`=0.
   - XOR with `a`=`b`=0x1234 gives `Z`=1.
4. **Backpressure:**
   - Setup: hold `out_ready`=0 for 3 cycles after `out_valid`, toggle `a`/`b` and pulse `in_valid`.
   - While stalled: outputs stay stable and `in_ready`=0.
   - On `out_ready`=1: one-cycle release, then `in_ready`=1, and the next request is accepted.
5. **Reset mid-RUN:**
   - Stimulus: start ADD `a`=0xFFFF, `b`=0x0001, then drive `rst_n` low in cycle c0+2.
   - During reset: `out_valid`=0, `in_ready`=1 and all outputs 0, asynchronously.
   - Afterwards: ADD 0x0001+0x0001, `cIn`=0 gives 0x0002 with `cOut`=0 (no stale carry).
6. **Random regression:** 2000 random `a`/`b`/`fn`/`cIn` with random `in_valid`/`out_ready` gaps, compared against a golden 17-bit sum/bitwise model for `result`, `cOut`, `N`, `Z`, `V` -> zero mismatches, with exactly one result per accepted request.
